// File: rtl/vga_timing_pkg.sv
// Shared types, standard mode constants and geometry helpers for the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned sync;
        int unsigned bp;
        int unsigned act;
        int unsigned fp;
    } axis_t;

    // Signals that travel through the output delay line together.
    typedef struct packed {
        logic frame_start;
        logic line_start;
        logic vsync;
        logic hsync;
        logic active;
    } sync_bus_t;

    localparam axis_t VGA640_H      = '{sync: 96, bp: 48, act: 640, fp: 16};
    localparam axis_t VGA640_V      = '{sync: 2, bp: 33, act: 480, fp: 10};
    localparam bit    VGA640_HS_POL = 1'b0;
    localparam bit    VGA640_VS_POL = 1'b0;

    localparam axis_t SVGA800_H      = '{sync: 120, bp: 64, act: 800, fp: 56};
    localparam axis_t SVGA800_V      = '{sync: 6, bp: 23, act: 600, fp: 37};
    localparam bit    SVGA800_HS_POL = 1'b1;
    localparam bit    SVGA800_VS_POL = 1'b1;

    function automatic int axis_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of depth N; N=0 is a plain wire.
module vga_delay_line #(
    parameter int             W       = 1,
    parameter int             N       = 0,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (N == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst, ce};
        assign dout = din;
    end else begin : g_shift
        logic [W-1:0] stage_q [N];
        logic [W-1:0] stage_d [N];

        always_comb begin
            for (int i = 0; i < N; i++) stage_d[i] = stage_q[i];
            if (ce) begin
                stage_d[0] = din;
                for (int i = 1; i < N; i++) stage_d[i] = stage_q[i-1];
            end
        end

        // NOTE: every stage is reset, so the deasserted sync levels appear on the pins immediately.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[N-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA scan generator: h/v counters, registered sync/enable/position outputs
// and a ce-qualified delay line that aligns sync with downstream pixel read latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = VGA640_H.sync,
    parameter int H_BP     = VGA640_H.bp,
    parameter int H_ACT    = VGA640_H.act,
    parameter int H_FP     = VGA640_H.fp,
    parameter int V_SYNC   = VGA640_V.sync,
    parameter int V_BP     = VGA640_V.bp,
    parameter int V_ACT    = VGA640_V.act,
    parameter int V_FP     = VGA640_V.fp,
    parameter bit HS_POL   = VGA640_HS_POL,
    parameter bit VS_POL   = VGA640_VS_POL,
    parameter int CNT_W    = 11,
    parameter int PIPE_DLY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic [CNT_W-1:0] row,
    output logic [CNT_W-1:0] col,
    output logic             addr_valid,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOT   = axis_total(H_SYNC, H_BP, H_ACT, H_FP);
    localparam int V_TOT   = axis_total(V_SYNC, V_BP, V_ACT, V_FP);
    localparam int MAX_TOT = (H_TOT > V_TOT) ? H_TOT : V_TOT;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);

    localparam sync_bus_t BUS_RST = '{frame_start: 1'b0, line_start: 1'b0,
                                      vsync: ~VS_POL, hsync: ~HS_POL, active: 1'b0};

    if (((MAX_TOT - 1) >> CNT_W) != 0) begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W=%0d cannot hold %0d", CNT_W, MAX_TOT - 1);
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_dly_check
        $error("vga_timing_gen: PIPE_DLY=%0d outside 0..7", PIPE_DLY);
    end

    logic             first_q, first_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] col_off, row_off;
    logic             visible;
    sync_bus_t        bus_q, bus_d, bus_dly;

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        first_d = first_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        bus_d   = bus_q;

        // The first enabled cycle after reset presents (0,0) instead of advancing past it.
        if (ce) begin
            first_d = 1'b0;
            if (!first_q) begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
                end else begin
                    h_cnt_d = h_cnt_q + CNT_W'(1);
                end
            end
        end

        // Positions before the active window wrap to large values, so one compare per axis suffices.
        col_off = h_cnt_d - H_START;
        row_off = v_cnt_d - V_START;
        visible = (col_off < H_ACT_C) && (row_off < V_ACT_C);

        if (ce) begin
            col_d             = visible ? col_off : '0;
            row_d             = visible ? row_off : '0;
            bus_d.active      = visible;
            bus_d.hsync       = (h_cnt_d < H_SYNC_C) ? HS_POL : ~HS_POL;
            bus_d.vsync       = (v_cnt_d < V_SYNC_C) ? VS_POL : ~VS_POL;
            bus_d.line_start  = (h_cnt_d == '0);
            bus_d.frame_start = (h_cnt_d == '0) && (v_cnt_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b1;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            bus_q   <= BUS_RST;
        end else begin
            first_q <= first_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            bus_q   <= bus_d;
        end
    end

    vga_delay_line #(
        .W       ($bits(sync_bus_t)),
        .N       (PIPE_DLY),
        .RST_VAL (BUS_RST)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .din  (bus_q),
        .dout (bus_dly)
    );

    assign row         = row_q;
    assign col         = col_q;
    assign addr_valid  = bus_q.active;
    assign active      = bus_dly.active;
    assign hsync       = bus_dly.hsync;
    assign vsync       = bus_dly.vsync;
    assign line_start  = bus_dly.line_start;
    assign frame_start = bus_dly.frame_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA scan counter: generates hsync/vsync, display-enable and pixel row/col for any mode from porch/sync parameters.
- Adds programmable sync polarity, a pixel clock-enable so it can run from a faster system clock, frame/line strobes, and a configurable output delay that aligns sync with downstream VRAM read latency.
- Sits between the clock domain's VRAM/character-generator read port and the VGA pins.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- H_ACT, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- V_ACT, 480, active lines.
- V_FP, 10, vertical front porch in lines.
- HS_POL, 0, hsync asserted level (0 = active-low).
- VS_POL, 0, vsync asserted level (0 = active-low).
- CNT_W, 11, width of internal counters and row/col outputs.
- PIPE_DLY, 0, extra cycles (0..7) applied to hsync, vsync, active and the strobes, but not to row/col.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ce  in  1  pixel enable; counters advance only when ce=1
- row  out  CNT_W  active line index, 0..V_ACT-1; 0 when not active
- col  out  CNT_W  active pixel index, 0..H_ACT-1; 0 when not active
- addr_valid  out  1  row/col are a visible pixel (undelayed)
- active  out  1  display enable, delayed by PIPE_DLY
- hsync  out  1  delayed by PIPE_DLY, polarity HS_POL
- vsync  out  1  delayed by PIPE_DLY, polarity VS_POL
- line_start  out  1  one-cycle pulse at h=0 of each line, delayed by PIPE_DLY
- frame_start  out  1  one-cycle pulse at h=0, v=0, delayed by PIPE_DLY

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Frame geometry:
  - H_TOT = H_SYNC+H_BP+H_ACT+H_FP; V_TOT likewise.
  - Line order is sync, back porch, active, front porch.
  - H_START = H_SYNC+H_BP; V_START = V_SYNC+V_BP.
- Counters:
  - h_cnt 0..H_TOT-1 and v_cnt 0..V_TOT-1 are registers.
  - On clk with ce=1: h_cnt increments; at H_TOT-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt=H_TOT-1 and v_cnt=V_TOT-1.
  - ce=0: all state and outputs hold; strobes are also held, so they must be qualified with ce downstream.
- Output registers: outputs are registered from the next counter value, so in each cycle the outputs describe the current (h_cnt, v_cnt).
  - hsync asserted when h_cnt < H_SYNC.
  - vsync asserted when v_cnt < V_SYNC.
  - addr_valid = (H_START <= h_cnt < H_START+H_ACT) and (V_START <= v_cnt < V_START+V_ACT).
  - When addr_valid=1: col = h_cnt-H_START and row = v_cnt-V_START. When addr_valid=0: col = 0 and row = 0; wrap-around garbage is never exposed.
- Delay line:
  - With PIPE_DLY=N, active/hsync/vsync/line_start/frame_start equal the undelayed values N ce-qualified cycles later; the delay line advances only on ce.
  - Intended use: a read issued with row/col returns its pixel in the same cycle that active is asserted.
  - With PIPE_DLY=0, active equals addr_valid.
- Reset (asynchronous, any point in the frame):
  - h_cnt, v_cnt, row, col = 0; addr_valid, active, line_start, frame_start = 0.
  - hsync = ~HS_POL and vsync = ~VS_POL; every delay stage loads these deasserted values.
  - In the first ce cycle after reset release, the position is (0,0) and frame_start fires (after PIPE_DLY).
- Boundary cases:
  - H_ACT edge: col reaches H_ACT-1, then addr_valid falls.
  - Last line of the frame: v wrap and h wrap occur in the same cycle.
  - CNT_W must hold max(H_TOT, V_TOT)-1; an elaboration check fails otherwise.

Decomposition:
- Package vga_timing_pkg:
  - Mode constants for 640x480@60 (the defaults above) and 800x600@72: 120/64/800/56 horizontal and 6/23/600/37 vertical, positive polarity.
  - Helper function computing H_TOT/V_TOT.
- Sub-module vga_delay_line: parametrised width W and depth N shift register with ce and async reset value RST_VAL. Instantiated once with W=5 for the delayed signals; N=0 is a pass-through.

Test Plan:
- Defaults, ce=1, rst held then released:
  - During reset: hsync=1, vsync=1, active=0, row=col=0.
  - First cycle after release: hsync=0, frame_start=1.
- Defaults, ce=1, one full frame:
  - hsync low for exactly 96 of every 800 cycles.
  - vsync low for exactly 1600 cycles (2 lines).
  - frame_start period 420000 cycles; line_start period 800 cycles.
- Defaults: count addr_valid cycles per frame = 307200.
  - First visible pixel at h=144, v=35 with row=0, col=0.
  - Last visible pixel at row=479, col=639, followed by addr_valid=0 and row=col=0.
- PIPE_DLY=2: active rises exactly 2 cycles after addr_valid, and hsync is the undelayed hsync shifted by 2; with ce toggling 1/0, the shift is 4 clk.
- ce=1 every other cycle: frame_start period 840000 clk, and outputs are stable across ce=0 cycles.
- rst asserted mid-line (row=200, col=300), with no clock edge: outputs take their reset values immediately; after release, counting restarts at (0,0) with frame_start.
